// File: rtl/rv32i_pkg.sv
// Shared RV32I widths and the fetch payload carried from fetch to decode.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [1:0]  INSTR_ALIGN = 2'b00;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue: registered storage and pointers, head presented from storage,
// flush drops every in-flight entry.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    // Pop only a real entry; push at full only when the head leaves the same cycle.
    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & ((count_q < CNT_W'(DEPTH)) | pop_ok);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (reset && !flush && push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, reads instruction memory and queues {pc, instr}
// for decode; execute redirects flush the queue and reload the PC.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 109,
    parameter int unsigned DEPTH      = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_halted
);

    localparam int unsigned    CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] LAST_PC = XLEN'((IMEM_BYTES - 4) & ~32'd3);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redirect_target;
    logic [CNT_W-1:0] count;
    logic             halted;
    logic             pop;
    logic             push;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign redirect_target = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & INSTR_ALIGN};
    assign halted          = (pc_q > LAST_PC);
    assign pop             = inst_valid & inst_ready;
    assign push            = reset & ~redirect_valid & ~halted
                           & ((count < CNT_W'(DEPTH)) | pop);

    // PC: reset beats redirect, redirect beats sequential advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_target;
        end else if (push) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    assign wr_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .wr_data    (wr_entry),
        .count      (count),
        .head_valid (inst_valid),
        .head_data  (head)
    );

    assign imem_addr    = pc_q;
    assign inst_data    = head.instr;
    assign inst_pc      = head.pc;
    assign fetch_halted = halted;

endmodule
